// File: rtl/uart_rx_fifo.sv
// Oversampled UART receiver with a small valid/ready read FIFO and sticky error flags.
// Defining UART_RX_PARITY_EN adds a parity bit after the data bits, plus parity_odd / parity_err.
module uart_rx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             clken,
  input  logic                             rx,
  output logic                             rd_valid,
  input  logic                             rd_ready,
  output logic [DATA_BITS-1:0]             rd_data,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count,
  output logic                             framing_err,
  output logic                             overrun,
  input  logic                             err_clr
`ifdef UART_RX_PARITY_EN
  ,
  input  logic                             parity_odd,
  output logic                             parity_err
`endif
);
  // state     | meaning
  // IDLE      | line idle, waiting for a low level
  // START     | timing to mid start bit, rejects glitches
  // DATA      | sampling data bits LSB first at mid-bit
  // PARITY    | sampling the parity bit (parity build only)
  // STOP      | sampling the stop bit, pushes good words
  // WAIT_IDLE | framing error seen, waiting for the line to go high
  localparam int CW = $clog2(OVERSAMPLE);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int NW = $clog2(FIFO_DEPTH+1);
  localparam logic [CW-1:0] CNT_MID  = CW'(OVERSAMPLE/2 - 1);
  localparam logic [CW-1:0] CNT_WRAP = CW'(OVERSAMPLE - 1);
  localparam logic [2:0]    IDX_LAST = 3'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    WAIT_IDLE
  } state_t;

  state_t               state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [2:0]           idx, idx_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 rx_meta, rx_s;
  logic                 push_req, frm_set;
  logic                 full, pop, push;
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
`ifdef UART_RX_PARITY_EN
  logic                 par_bad, par_bad_n, par_set;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
`ifdef UART_RX_PARITY_EN
      par_bad <= 1'b0;
`endif
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      shreg <= shreg_n;
`ifdef UART_RX_PARITY_EN
      par_bad <= par_bad_n;
`endif
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    idx_n    = idx;
    shreg_n  = shreg;
    push_req = 1'b0;
    frm_set  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_n = par_bad;
    par_set   = 1'b0;
`endif
    if (clken) begin
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state_n = START;
            cnt_n   = '0;
          end
        end
        START: begin
          if (cnt == CNT_MID) begin
            if (rx_s) begin
              state_n = IDLE;
            end else begin
              state_n = DATA;
              cnt_n   = '0;
              idx_n   = '0;
`ifdef UART_RX_PARITY_EN
              par_bad_n = 1'b0;
`endif
            end
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        DATA: begin
          cnt_n = cnt + 1'b1;
          if (cnt == CNT_WRAP) begin
            shreg_n = {rx_s, shreg[DATA_BITS-1:1]};
            idx_n   = idx + 1'b1;
            if (idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_n = PARITY;
`else
              state_n = STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          cnt_n = cnt + 1'b1;
          if (cnt == CNT_WRAP) begin
            state_n = STOP;
            if (rx_s != (^shreg ^ parity_odd)) begin
              par_bad_n = 1'b1;
              par_set   = 1'b1;
            end
          end
        end
`endif
        STOP: begin
          cnt_n = cnt + 1'b1;
          if (cnt == CNT_WRAP) begin
            if (rx_s) begin
              // Back to IDLE at mid stop bit leaves half a bit of slack for a fast transmitter.
              state_n = IDLE;
`ifdef UART_RX_PARITY_EN
              push_req = !par_bad;
`else
              push_req = 1'b1;
`endif
            end else begin
              state_n = WAIT_IDLE;
              frm_set = 1'b1;
            end
          end
        end
        WAIT_IDLE: begin
          if (rx_s) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
  assign rd_valid = (fifo_count != '0);
  assign full     = (fifo_count == NW'(FIFO_DEPTH));
  assign pop      = rd_valid & rd_ready;
  assign push     = push_req & (~full | pop);
  assign rd_data  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      framing_err <= 1'b0;
      overrun     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err  <= 1'b0;
`endif
    end else begin
      if (frm_set)                  framing_err <= 1'b1;
      else if (err_clr)             framing_err <= 1'b0;
      if (push_req & full & ~pop)   overrun     <= 1'b1;
      else if (err_clr)             overrun     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      if (par_set)                  parity_err  <= 1'b1;
      else if (err_clr)             parity_err  <= 1'b0;
`endif
    end
  end

endmodule
